// File: rtl/mem_stage_sb.sv
// Memory stage with a circular store buffer between the EX/MEM register and a multi-cycle memory.
// Optional load forwarding from the store buffer is enabled by defining MEM_SB_FWD_EN.
module mem_stage_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_valid,
  input  logic                          ex_rd,
  input  logic                          ex_wr,
  input  logic [ADDR_W-1:0]             ex_addr,
  input  logic [DATA_W-1:0]             ex_wdata,
  input  logic                          ex_halt,
  output logic [DATA_W-1:0]             mem_result,
  output logic                          stall_mem,
  output logic                          err,
  output logic                          err_mem,
  output logic [$clog2(SB_DEPTH):0]     sb_count,
  output logic                          halt_done,
  output logic [ADDR_W-1:0]             m_addr,
  output logic [DATA_W-1:0]             m_wdata,
  output logic                          m_rd,
  output logic                          m_wr,
  input  logic [DATA_W-1:0]             m_data,
  input  logic                          m_done,
  input  logic                          m_stall,
  input  logic                          m_err
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  // Handshake: an instruction is consumed when ex_valid=1, ex_halt=0 and stall_mem=0;
  // the pipeline holds every ex_* input stable while stall_mem=1.
  state_t              state, state_n;
  logic [ADDR_W-1:0]   sb_addr [SB_DEPTH];
  logic [DATA_W-1:0]   sb_data [SB_DEPTH];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count, count_n;
  logic                is_ld, is_st, sb_full, sb_empty;
  logic                drain_done, load_done, push, pop, consumed;
  logic                fwd_hit, ld_may_issue, ld_miss;
  logic [DATA_W-1:0]   fwd_data;
  logic                unused_m_stall;

  assign unused_m_stall = m_stall;

  assign is_ld      = ex_valid & ex_rd & ~ex_wr & ~ex_halt;
  assign is_st      = ex_valid & ex_wr & ~ex_rd & ~ex_halt;
  assign err        = ex_valid & ex_rd & ex_wr;
  assign sb_full    = (count == CNT_W'(SB_DEPTH));
  assign sb_empty   = (count == '0);
  assign drain_done = (state == S_DRAIN) & m_done;
  assign load_done  = (state == S_LOAD) & m_done;

`ifdef MEM_SB_FWD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CNT_W'(i) < count && sb_addr[head + PTR_W'(i)] == ex_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[head + PTR_W'(i)];
      end
    end
  end
  assign ld_may_issue = 1'b1;
`else
  // Without forwarding a load may only go to memory once every older store has drained.
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
  assign ld_may_issue = sb_empty;
`endif

  assign ld_miss = is_ld & ~fwd_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (ld_miss && ld_may_issue) state_n = S_LOAD;
        else if (!sb_empty)          state_n = S_DRAIN;
      end
      S_LOAD:  if (m_done) state_n = S_IDLE;
      S_DRAIN: if (m_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    stall_mem  = 1'b0;
    mem_result = '0;
    if (is_ld) begin
      if (fwd_hit)        mem_result = fwd_data;
      else if (load_done) mem_result = m_data;
      else                stall_mem  = 1'b1;
    end else if (is_st) begin
      // A completing drain frees a slot in the same cycle, so a full SB still accepts.
      stall_mem = sb_full & ~drain_done;
    end
  end

  assign push     = is_st & ~stall_mem;
  assign pop      = drain_done;
  assign consumed = (is_ld | is_st) & ~stall_mem;
  assign count_n  = count + CNT_W'(push) - CNT_W'(pop);
  assign sb_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= ex_addr;
      sb_data[tail] <= ex_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      err_mem   <= 1'b0;
      halt_done <= 1'b0;
    end else begin
      count     <= count_n;
      m_rd      <= (state_n == S_LOAD);
      m_wr      <= (state_n == S_DRAIN);
      halt_done <= ex_halt & (count_n == '0) & (state_n == S_IDLE);
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (state == S_IDLE && state_n == S_LOAD) begin
        m_addr <= ex_addr;
      end else if (state == S_IDLE && state_n == S_DRAIN) begin
        m_addr  <= sb_addr[head];
        m_wdata <= sb_data[head];
      end
      if ((consumed && ex_addr[0]) || (state != S_IDLE && m_err)) err_mem <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: vector table plus hand-written multi-cycle sequences,
// a latency-configurable memory responder and a drain-order scoreboard.
module tb_mem_stage_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_rd = 1'b0, ex_wr = 1'b0, ex_halt = 1'b0;
  logic [15:0] ex_addr = '0, ex_wdata = '0;
  logic [15:0] mem_result, m_addr, m_wdata;
  logic        stall_mem, err, err_mem, halt_done, m_rd, m_wr;
  logic [2:0]  sb_count;
  logic [15:0] m_data = '0;
  logic        m_done = 1'b0, m_stall = 1'b0, m_err = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  int          mem_lat = 1;
  int          req_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] mem_arr [logic [15:0]];

  typedef struct {
    logic        is_ld;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  mem_stage_sb #(.DATA_W(16), .ADDR_W(16), .SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_halt(ex_halt),
    .mem_result(mem_result), .stall_mem(stall_mem), .err(err), .err_mem(err_mem),
    .sb_count(sb_count), .halt_done(halt_done),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_data(m_data), .m_done(m_done), .m_stall(m_stall), .m_err(m_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory responder: completes each request mem_lat cycles after it appears.
  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    m_data = '0;
    if (!rst) begin
      req_cnt = 0;
    end else if (m_rd || m_wr) begin
      m_stall = 1'b1;
      if (req_cnt >= mem_lat - 1) begin
        m_done  = 1'b1;
        m_stall = 1'b0;
        req_cnt = 0;
        if (m_rd) begin
          m_data = mem_arr.exists(m_addr) ? mem_arr[m_addr] : (m_addr ^ 16'hA5A5);
        end else begin
          mem_arr[m_addr] = m_wdata;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL drain_unexpected: got %h expected no write", {m_addr, m_wdata});
          end else begin
            chk("drain_order", {m_addr, m_wdata}, exp_q.pop_front());
          end
        end
      end else begin
        req_cnt++;
      end
    end else begin
      m_stall = 1'b0;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and holds it until consumed; returns stall cycles and load data.
  task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] data, output int stalls, output logic [15:0] res);
    bit done = 0;
    ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_addr = addr; ex_wdata = data; ex_halt = 1'b0;
    stalls = 0;
    res = '0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!stall_mem) begin
        res = mem_result;
        done = 1;
      end else begin
        stalls++;
      end
      align();
    end
    ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
    if (wr && done) exp_q.push_back({addr, data});
    chk("op_accepted", done, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (sb_count == 0 && !m_rd && !m_wr) ok = 1;
    end
    chk("wait_idle", ok, 1);
    align();
  endtask

  initial begin
    int          st;
    logic [15:0] res;
    logic [15:0] rd_addr;
    bit          seen;

    // Reset with a store held at the inputs
    ex_valid = 1'b1; ex_wr = 1'b1; ex_addr = 16'h0010; ex_wdata = 16'hBEEF;
    mem_lat = 3;
    repeat (3) @(negedge clk);
    chk("rst_m_rd", m_rd, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_mem_result", mem_result, 0);
    chk("rst_err_mem", err_mem, 0);
    chk("rst_halt_done", halt_done, 0);
    chk("rst_sb_count", sb_count, 0);
    chk("rst_stall", stall_mem, 0);
    align();
    rst = 1'b1;
    do_op(0, 1, 16'h0010, 16'hBEEF, st, res);
    chk("first_store_stalls", st, 0);
    @(negedge clk);
    chk("count_after_store", sb_count, 1);
    chk("err_normal", err, 0);
    align();

    // Two stores to the same address, then a load of it
    do_op(0, 1, 16'h0010, 16'h1234, st, res);
    do_op(1, 0, 16'h0010, 16'h0000, st, res);
    chk("fwd_youngest_data", res, 16'h1234);
`ifdef MEM_SB_FWD_EN
    chk("fwd_hit_stalls", st, 0);
`else
    chk("nofwd_load_stalled", st > 0, 1);
`endif

    // Vector table
    wait_idle();
    mem_lat = 1;
    vecs[0] = '{1'b0, 16'h0100, 16'h1111, 16'h0000};
    vecs[1] = '{1'b0, 16'h0102, 16'h2222, 16'h0000};
    vecs[2] = '{1'b1, 16'h0102, 16'h0000, 16'h2222};
    vecs[3] = '{1'b1, 16'h0200, 16'h0000, 16'hA7A5};
    vecs[4] = '{1'b1, 16'h0100, 16'h0000, 16'h1111};
    foreach (vecs[i]) begin
      do_op(vecs[i].is_ld, ~vecs[i].is_ld, vecs[i].addr, vecs[i].wdata, st, res);
      if (vecs[i].is_ld) chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
    end

    // Minimum miss penalty on an empty, idle SB
    wait_idle();
    do_op(1, 0, 16'h0500, 16'h0000, st, res);
    chk("miss_min_stalls", st, 1);
    chk("miss_min_result", res, 16'hA0A5);

    // Full SB: fifth store accepted in the first drain's m_done cycle
    wait_idle();
    mem_lat = 5;
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1, 16'h0300 + 16'(2 * i), 16'h3000 + 16'(i), st, res);
      chk($sformatf("full_store%0d_stalls", i), st, 0);
    end
    do_op(0, 1, 16'h0308, 16'h3004, st, res);
    chk("full_store5_stalls", st, 2);
    @(negedge clk);
    chk("full_count_stays", sb_count, 4);
    align();

    // Load miss arriving while a drain is in flight
    wait_idle();
    mem_lat = 4;
    do_op(0, 1, 16'h0400, 16'h4444, st, res);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_wr) seen = 1;
    end
    chk("drain_started", seen, 1);
    align();
    seen = 0;
    rd_addr = '0;
    fork
      begin
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk);
          if (m_rd) begin
            seen = 1;
            rd_addr = m_addr;
            chk("load_after_drain_count", sb_count, 0);
          end
        end
      end
      do_op(1, 0, 16'h0020, 16'h0000, st, res);
    join
    chk("load_m_addr", rd_addr, 16'h0020);
    chk("load_during_drain_stalls", st, 7);
    chk("load_during_drain_result", res, 16'hA585);

    // Unaligned access and conflicting rd/wr
    wait_idle();
    mem_lat = 1;
    chk("err_mem_clear", err_mem, 0);
    do_op(1, 0, 16'h0003, 16'h0000, st, res);
    chk("unaligned_result", res, 16'hA5A6);
    @(negedge clk);
    chk("err_mem_set", err_mem, 1);
    align();
    do_op(0, 1, 16'h0600, 16'h6666, st, res);
    @(negedge clk);
    chk("err_mem_sticky", err_mem, 1);
    align();
    ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b1; ex_addr = 16'h0610;
    @(negedge clk);
    chk("err_both", err, 1);
    chk("err_both_no_stall", stall_mem, 0);
    align();
    ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;

    // Halt drains the SB in order and blocks new stores
    wait_idle();
    mem_lat = 2;
    for (int i = 0; i < 3; i++) do_op(0, 1, 16'h0700 + 16'(2 * i), 16'h7000 + 16'(i), st, res);
    ex_halt = 1'b1; ex_valid = 1'b1; ex_wr = 1'b1; ex_addr = 16'h0800; ex_wdata = 16'hDEAD;
    @(negedge clk);
    chk("halt_done_early", halt_done, 0);
    chk("halt_no_stall", stall_mem, 0);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (halt_done) seen = 1;
    end
    chk("halt_done_seen", seen, 1);
    chk("halt_count_zero", sb_count, 0);
    chk("halt_no_request", m_wr | m_rd, 0);
    repeat (3) @(negedge clk);
    chk("halt_store_blocked", sb_count, 0);
    chk("halt_all_drained", exp_q.size(), 0);
    align();
    ex_halt = 1'b0; ex_valid = 1'b0; ex_wr = 1'b0;

    // Reset clears the sticky error
    rst = 1'b0;
    #1;
    chk("reset_err_mem", err_mem, 0);
    chk("reset_sb_count", sb_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_sb.md
# mem_stage_sb

Memory-stage block for the pipelined processor. It sits between the EX/MEM pipeline register and a multi-cycle, non-ideal memory system (Rd/Wr/Done/Stall handshake) and replaces the direct memory hookup with a parametrised store buffer (SB). Stores retire without waiting for memory, and loads are forwarded from the SB when they hit. Loads that miss the SB are issued to memory with priority, and the SB drains in the background and on halt.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width; addresses are byte addresses, and a word access must have addr[0]=0
- SB_DEPTH, 4, number of SB entries; power of two, at least 2

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  a new memory instruction is presented
- ex_rd  in  1  load
- ex_wr  in  1  store
- ex_addr  in  ADDR_W  address (ALU result)
- ex_wdata  in  DATA_W  store data
- ex_halt  in  1  halt; blocks new requests and forces the SB to drain
- mem_result  out  DATA_W  load data
- stall_mem  out  1  hold the pipeline; the instruction is not consumed this cycle
- err  out  1  ex_valid asserted with ex_rd and ex_wr both high
- err_mem  out  1  sticky; set by an unaligned access or by m_err
- sb_count  out  $clog2(SB_DEPTH)+1  SB occupancy
- halt_done  out  1  ex_halt high, SB empty and FSM in IDLE
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rd  out  1  memory read request
- m_wr  out  1  memory write request
- m_data  in  DATA_W  memory read data
- m_done  in  1  request complete
- m_stall  in  1  memory busy (informational only; requests are held until m_done)
- m_err  in  1  memory error

## Operation
- Handshake: an instruction is consumed in the cycle where ex_valid=1 and stall_mem=0. The pipeline holds all ex_* inputs stable while stall_mem=1.
- ex_halt=1 turns off consumption. Cycles with ex_valid=0 or ex_halt=1 drive stall_mem=0.
- Store:
  - Pushed at the SB tail with {addr, data}.
  - stall_mem=1 while the SB is full. The one exception is a cycle where a drain completes (DRAIN state and m_done=1): that cycle pops and pushes simultaneously and stall_mem=0.
- Load, SB hit: the youngest SB entry with an equal full address supplies mem_result combinationally, and stall_mem=0.
- Load, SB miss: stall_mem=1 until the load's m_done cycle. In that cycle mem_result=m_data and stall_mem=0.
- FSM (registered):
  - IDLE to LOAD when a valid load misses and ex_halt=0. Loads win over drain.
  - IDLE to DRAIN when the SB is non-empty and no missing load is pending.
  - LOAD to IDLE on m_done.
  - DRAIN to IDLE on m_done, popping the head entry. A load arriving during DRAIN waits for this return to IDLE.
- Memory outputs are registered:
  - m_rd=1 throughout LOAD, m_wr=1 throughout DRAIN.
  - m_addr/m_wdata stay constant for the whole request. There is never more than one outstanding request.
- The SB is a circular FIFO with head and tail pointers that wrap modulo SB_DEPTH, plus a count. Full means count==SB_DEPTH and empty means count==0.
- err_mem: set on a consumed access with ex_addr[0]=1 (that access still proceeds), or when m_err=1 during a request. It clears only on reset.
- mem_result=0 when no load is completing.

## Timing
- Reset (asynchronous assert, synchronous release): SB empty, FSM IDLE, sb_count=0. The outputs m_rd, m_wr, m_addr, m_wdata, mem_result, err_mem and halt_done are all 0. The combinational stall_mem and err then follow their inputs.
- Reset during any request drops m_rd/m_wr immediately. The memory system is expected to be reset at the same time.
- Store accepted at cycle T: sb_count increments at T+1.
- SB-hit load: zero stall cycles.
- Miss load accepted at cycle T: m_rd goes high at T+1. If m_done first asserts at cycle D≥T+1, stall_mem is high for cycles T..D-1, so the minimum penalty is 1 stall cycle.
- Drain: the FSM passes through one IDLE cycle between consecutive DRAIN requests.
- halt_done can assert no earlier than the cycle after the final drain's m_done.

## Configuration
- MEM_SB_FWD_EN defined: load forwarding from the SB is enabled, as described above.
- MEM_SB_FWD_EN undefined: no forwarding. A load with sb_count≠0 stalls until the SB has fully drained and the FSM is in IDLE, then issues as a miss. The address comparators are not synthesised.

## Test plan
- Reset with a store held at the inputs: every registered output is 0 and sb_count=0. After rst deasserts, the store at 0x0010 is accepted in the first cycle.
- Store 0x0010←0xBEEF, store 0x0010←0x1234, then load 0x0010: mem_result=0x1234 with 0 stall cycles when MEM_SB_FWD_EN is defined. Without the macro: stall until both writes drain, then 0x1234.
- SB_DEPTH=4, m_done delayed 5 cycles: five back-to-back stores. The fifth stalls until the first drain's m_done and is accepted in that same cycle, and sb_count stays at 4.
- Load miss to 0x0020 while DRAIN is active: the load waits for the drain's m_done, then the m_rd request goes out with m_addr=0x0020. stall_mem drops in the load's m_done cycle with mem_result=m_data.
- Load to 0x0003: err_mem is set and stays set across later accesses until reset. A cycle with ex_valid=1, ex_rd=1 and ex_wr=1 gives err=1.
- Three stores, then ex_halt=1: the SB drains in FIFO order with no new requests accepted. halt_done=1 once sb_count=0 and the FSM is in IDLE.
